// File: rtl/iram_arb_pkg.sv
// Shared constants and state encoding for the instruction-RAM monitor arbiter.
package iram_arb_pkg;

    localparam int IRAM_ADR_W = 12;
    localparam int FAIR_LIMIT = 4;
    localparam int FAIR_GAP   = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

endpackage

// File: rtl/iram_mon_arbiter.sv
// Arbitrates monitor read/write access to the instruction RAM against CPU fetch.
// Define IRAM_ARB_FAIR_EN to insert a fetch gap after every 4th held transaction.
module iram_mon_arbiter
    import iram_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_run,
    input  logic                  mon_req,
    input  logic                  mon_we,
    input  logic [IRAM_ADR_W+1:2] mon_adr,
    input  logic [31:0]           mon_wdata,
    output logic                  mon_ack,
    output logic [31:0]           mon_rdata,
    output logic                  mon_busy,
    output logic                  fetch_hold,
    output logic                  i_read_sel,
    output logic [IRAM_ADR_W+1:2] i_ram_radr,
    output logic [IRAM_ADR_W+1:2] i_ram_wadr,
    output logic [31:0]           i_ram_wdata,
    output logic                  i_ram_wen,
    input  logic [31:0]           i_ram_rdata
);

    state_t                  state;
    state_t                  state_next;
    logic                    lat_we;
    logic [IRAM_ADR_W+1:2]   lat_adr;
    logic [31:0]             lat_wdata;
    logic                    hold_mode;
    logic                    accept;
    logic                    fair_trip;
    logic                    gap_active;
    logic                    gap_done;

    assign accept = (state == ST_IDLE) && mon_req;

`ifdef IRAM_ARB_FAIR_EN
    logic [2:0] fair_cnt;
    logic       gap_cnt;

    // fair_trip fires in RELEASE of the FAIR_LIMIT-th consecutive held transaction
    assign fair_trip  = hold_mode && (fair_cnt == 3'(FAIR_LIMIT - 1));
    assign gap_active = (state == ST_GAP);
    assign gap_done   = gap_active && (gap_cnt == 1'(FAIR_GAP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fair_cnt <= 3'd0;
            gap_cnt  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:    if (!mon_req) fair_cnt <= 3'd0;
                ST_RELEASE: if (hold_mode) fair_cnt <= fair_cnt + 3'd1;
                ST_GAP: begin
                    if (gap_done) begin
                        gap_cnt  <= 1'b0;
                        fair_cnt <= 3'd0;
                    end else begin
                        gap_cnt  <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign fair_trip  = 1'b0;
    assign gap_active = 1'b0;
    assign gap_done   = 1'b0;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (mon_req) state_next = cpu_run ? ST_DRAIN : ST_ACCESS;
            ST_DRAIN:   state_next = ST_ACCESS;
            ST_ACCESS:  state_next = lat_we ? ST_RELEASE : ST_CAPTURE;
            ST_CAPTURE: state_next = ST_RELEASE;
            ST_RELEASE: state_next = fair_trip ? ST_GAP : ST_IDLE;
            ST_GAP:     if (gap_done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_we    <= 1'b0;
            lat_adr   <= '0;
            lat_wdata <= '0;
            hold_mode <= 1'b0;
            mon_rdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we    <= mon_we;
                lat_adr   <= mon_adr;
                lat_wdata <= mon_wdata;
                hold_mode <= cpu_run;
            end
            if (state == ST_CAPTURE) mon_rdata <= i_ram_rdata;
        end
    end

    // Hold is sticky once taken (hold_mode) but can still be raised late by cpu_run.
    assign mon_busy    = (state != ST_IDLE);
    assign mon_ack     = (state == ST_RELEASE);
    assign fetch_hold  = mon_busy && (hold_mode || cpu_run) && !gap_active;
    assign i_read_sel  = ((state == ST_ACCESS) && !lat_we) || (state == ST_CAPTURE);
    assign i_ram_wen   = (state == ST_ACCESS) && lat_we;
    assign i_ram_radr  = i_read_sel ? lat_adr : '0;
    assign i_ram_wadr  = lat_adr;
    assign i_ram_wdata = lat_wdata;

endmodule

// File: doc/iram_mon_arbiter.md
IRAM_MON_ARBITER -- requirements
Module: iram_mon_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-003 SHALL have port cpu_run, input, 1: the CPU is fetching instructions.
REQ-004 SHALL have port mon_req, input, 1: monitor access request, sampled only in IDLE.
REQ-005 SHALL have port mon_we, input, 1: 1 = write, 0 = read; sampled with mon_req.
REQ-006 SHALL have port mon_adr, input, [13:2]: monitor word address.
REQ-007 SHALL have port mon_wdata, input, 32: monitor write data.
REQ-008 SHALL have port mon_ack, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port mon_rdata, output, 32: read data, registered.
REQ-010 SHALL have port mon_busy, output, 1: high in any state other than IDLE.
REQ-011 SHALL have port fetch_hold, output, 1: stall to the fetch stage.
REQ-012 SHALL have port i_read_sel, output, 1: selects the monitor address on the RAM read port.
REQ-013 SHALL have port i_ram_radr, output, [13:2]: RAM read address.
REQ-014 SHALL have port i_ram_wadr, output, [13:2]: RAM write address.
REQ-015 SHALL have port i_ram_wdata, output, 32: RAM write data.
REQ-016 SHALL have port i_ram_wen, output, 1: RAM write enable.
REQ-017 SHALL have port i_ram_rdata, input, 32: RAM read data, 1-cycle synchronous latency.

Function
REQ-018 SHALL implement the states IDLE, DRAIN, ACCESS, CAPTURE and RELEASE (plus GAP under REQ-031).
REQ-019 IDLE with mon_req=1 SHALL latch mon_we, mon_adr, mon_wdata and set hold_mode=cpu_run; next state is DRAIN if cpu_run=1, else ACCESS.
REQ-020 DRAIN SHALL last exactly one cycle, then go to ACCESS.
REQ-021 ACCESS for a write SHALL drive i_ram_wen=1 for exactly that cycle with the latched address and data, then go to RELEASE.
REQ-022 ACCESS for a read SHALL drive i_read_sel=1 and i_ram_radr=latched address, then go to CAPTURE.
REQ-023 CAPTURE SHALL keep i_read_sel=1, load mon_rdata from i_ram_rdata at the end of the cycle, then go to RELEASE.
REQ-024 RELEASE SHALL pulse mon_ack for one cycle, then go to IDLE; mon_rdata SHALL hold until the next CAPTURE.
REQ-025 fetch_hold SHALL equal mon_busy & (hold_mode | cpu_run):
- cpu_run rising mid-transaction asserts the hold immediately;
- cpu_run falling mid-transaction does not release it.
REQ-026 Outside the cases above: i_read_sel=0, i_ram_wen=0, i_ram_radr=0; mon_req is ignored while mon_busy=1.
REQ-027 Latency from mon_req (IDLE, cycle t) to mon_ack:
- read, held: t+4; read, unheld: t+3;
- write, held: t+3; write, unheld: t+2.
REQ-028 Back-to-back operation: a new mon_req SHALL be accepted in the first IDLE cycle after RELEASE.

Reset
REQ-029 On rst_n low, SHALL enter IDLE and clear hold_mode, mon_ack, mon_rdata, fetch_hold, i_read_sel, i_ram_wen and every latched address and data register to 0.
REQ-030 A reset mid-transaction SHALL abort it: no mon_ack, and no write issued after reset.

Configuration
REQ-031 With IRAM_ARB_FAIR_EN defined:
- a 3-bit counter counts completed held transactions;
- the counter clears on any IDLE cycle with mon_req=0;
- on the 4th completed held transaction, RELEASE goes to GAP instead of IDLE;
- GAP lasts 2 cycles with fetch_hold=0 and mon_busy=1, then goes to IDLE and clears the counter.
REQ-032 Without IRAM_ARB_FAIR_EN, the GAP state and the counter SHALL be absent and RELEASE always goes to IDLE.

Structure
REQ-033 Package iram_arb_pkg SHALL hold:
- the state encoding typedef;
- IRAM_ADR_W=12, FAIR_LIMIT=4, FAIR_GAP=2.
REQ-034 SHALL be one flat module with no sub-modules.

Verification
REQ-035 cpu_run=0, write 0x12345678 to address 0x010 -> i_ram_wen pulses at t+1, mon_ack at t+2, fetch_hold stays 0.
REQ-036 cpu_run=1, read address 0x010 -> fetch_hold high t+1..t+4, i_read_sel high t+2..t+3, mon_ack at t+4, mon_rdata=0x12345678.
REQ-037 cpu_run drops during DRAIN -> fetch_hold stays high through RELEASE.
REQ-038 rst_n asserted during CAPTURE -> all outputs 0, no mon_ack; the next request completes normally.
REQ-039 Five back-to-back held reads with IRAM_ARB_FAIR_EN -> 2-cycle fetch_hold=0 gap after the 4th; without the macro -> no gap.
